// File: rtl/cart_mem_pkg.sv
// Shared types and constants for the cartridge memory bridge: FSM state
// encoding, byte-lane enables and default external base addresses.
package cart_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_ROM = 2'd1,
        RD_RAM = 2'd2,
        WR_RAM = 2'd3
    } state_t;

    // Byte-lane enables on the 16-bit external word; bit0 covers [7:0].
    localparam logic [1:0] BE_NONE = 2'b00;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_WORD = 2'b11;

    localparam int          DEF_MEM_AW   = 22;
    localparam logic [21:0] DEF_ROM_BASE = 22'h000000;
    localparam logic [21:0] DEF_RAM_BASE = 22'h200000;

    // Little-endian lane select: byte address bit0 picks the upper byte.
    function automatic logic [1:0] lane_be(input logic sel);
        return sel ? BE_HI : BE_LO;
    endfunction

endpackage

// File: rtl/cart_mem_bridge_if.sv
// External word-memory port: req/ack handshake towards the HyperRAM/SDRAM
// controller. The bridge is the master, the memory controller the slave.
interface cart_mem_bridge_if
    import cart_mem_pkg::*;
#(
    parameter int MEM_AW = DEF_MEM_AW
) ();

    logic [MEM_AW-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [15:0]       mem_wdata;
    logic [1:0]        mem_be;
    logic [15:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_addr, mem_rd, mem_wr, mem_wdata, mem_be,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_addr, mem_rd, mem_wr, mem_wdata, mem_be,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/cart_line_cache.sv
// One-entry line cache: valid/tag/16-bit data, hit compare, byte select for
// reads, byte update for write-through and flush. Invalid lines read 8'hFF.
module cart_line_cache
    import cart_mem_pkg::*;
#(
    parameter int AW = DEF_MEM_AW
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          flush,
    input  logic [AW-1:0] lookup_tag,
    input  logic          lookup_sel,
    output logic          hit,
    output logic [7:0]    rd_byte,
    input  logic          fill_en,
    input  logic [AW-1:0] fill_tag,
    input  logic [15:0]   fill_data,
    input  logic          upd_en,
    input  logic [AW-1:0] upd_tag,
    input  logic          upd_sel,
    input  logic [7:0]    upd_byte
);

    logic          valid_q;
    logic [AW-1:0] tag_q;
    logic [15:0]   data_q;
    logic [1:0]    upd_be;

    assign upd_be  = lane_be(upd_sel);
    assign hit     = valid_q && (tag_q == lookup_tag);
    assign rd_byte = !valid_q   ? 8'hFF :
                     lookup_sel ? data_q[15:8] : data_q[7:0];

    // Valid bit: cleared by reset or flush (flush beats a same-cycle fill).
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (reset || flush) begin
            valid_q <= 1'b0;
        end else if (fill_en) begin
            valid_q <= 1'b1;
        end
    end

    // Tag/data store: whole-word fill, or byte update on a write-through tag match.
    // NOTE: tag and data carry no reset; valid_q alone qualifies them.
    always_ff @(posedge clk_sys) begin
        if (fill_en) begin
            tag_q  <= fill_tag;
            data_q <= fill_data;
        end else if (upd_en && (upd_tag == tag_q)) begin
            if (upd_be[0]) data_q[7:0]  <= upd_byte;
            if (upd_be[1]) data_q[15:8] <= upd_byte;
        end
    end

endmodule

// File: rtl/cart_mem_bridge.sv
// Cartridge ROM/RAM responder: byte-wide reads/writes from the bank controller
// mapped onto a 16-bit external word port, with one line cache per space and
// a stall output while a miss or write is outstanding.
module cart_mem_bridge
    import cart_mem_pkg::*;
#(
    parameter int              MEM_AW   = DEF_MEM_AW,
    parameter logic [MEM_AW-1:0] ROM_BASE = MEM_AW'(DEF_ROM_BASE),
    parameter logic [MEM_AW-1:0] RAM_BASE = MEM_AW'(DEF_RAM_BASE)
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [22:0]              rom_addr,
    input  logic                     rom_rd,
    output logic [7:0]               rom_data,
    input  logic [16:0]              ram_addr,
    input  logic                     ram_rd,
    input  logic                     ram_wr,
    input  logic [7:0]               ram_di,
    output logic [7:0]               ram_do,
    output logic                     cpu_stall,
    cart_mem_bridge_if.master        mem
);

    state_t            state_q, state_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]        mem_be_q, mem_be_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    logic              wr_pend_q, wr_pend_d;
    logic [16:0]       wr_pend_addr_q, wr_pend_addr_d;
    logic [7:0]        wr_pend_data_q, wr_pend_data_d;
    logic              fill_kill_q, fill_kill_d;
    logic              ram_wr_q;

    logic              wr_edge;
    logic [MEM_AW-1:0] rom_tag, ram_tag, upd_tag;
    logic              rom_hit, ram_hit, rom_miss, ram_miss;
    logic              rom_fill_en, ram_fill_en, upd_en;
    logic [16:0]       w_addr;
    logic [7:0]        w_data;

    assign wr_edge  = ram_wr && !ram_wr_q;
    assign rom_tag  = ROM_BASE + MEM_AW'(rom_addr[22:1]);
    assign ram_tag  = RAM_BASE + MEM_AW'(ram_addr[16:1]);
    assign rom_miss = rom_rd && !rom_hit;
    assign ram_miss = ram_rd && !ram_hit;

    assign mem.mem_rd    = mem_rd_q;
    assign mem.mem_wr    = mem_wr_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_wdata = mem_wdata_q;

    cart_line_cache #(.AW(MEM_AW)) u_rom_cache (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .flush      (flush),
        .lookup_tag (rom_tag),
        .lookup_sel (rom_addr[0]),
        .hit        (rom_hit),
        .rd_byte    (rom_data),
        .fill_en    (rom_fill_en),
        .fill_tag   (mem_addr_q),
        .fill_data  (mem.mem_rdata),
        .upd_en     (1'b0),
        .upd_tag    (mem_addr_q),
        .upd_sel    (1'b0),
        .upd_byte   (8'h00)
    );

    cart_line_cache #(.AW(MEM_AW)) u_ram_cache (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .flush      (flush),
        .lookup_tag (ram_tag),
        .lookup_sel (ram_addr[0]),
        .hit        (ram_hit),
        .rd_byte    (ram_do),
        .fill_en    (ram_fill_en),
        .fill_tag   (mem_addr_q),
        .fill_data  (mem.mem_rdata),
        .upd_en     (upd_en),
        .upd_tag    (upd_tag),
        .upd_sel    (w_addr[0]),
        .upd_byte   (w_data)
    );

    // State, registered memory-port outputs, pending write and edge history.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q        <= IDLE;
            mem_rd_q       <= 1'b0;
            mem_wr_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_be_q       <= BE_NONE;
            mem_wdata_q    <= 16'h0000;
            wr_pend_q      <= 1'b0;
            wr_pend_addr_q <= 17'h0;
            wr_pend_data_q <= 8'h00;
            fill_kill_q    <= 1'b0;
            ram_wr_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            mem_rd_q       <= mem_rd_d;
            mem_wr_q       <= mem_wr_d;
            mem_addr_q     <= mem_addr_d;
            mem_be_q       <= mem_be_d;
            mem_wdata_q    <= mem_wdata_d;
            wr_pend_q      <= wr_pend_d;
            wr_pend_addr_q <= wr_pend_addr_d;
            wr_pend_data_q <= wr_pend_data_d;
            fill_kill_q    <= fill_kill_d;
            ram_wr_q       <= ram_wr;
        end
    end

    // Next state, request launch/retire, pending-write capture, stall and fills.
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d        = state_q;
        mem_rd_d       = mem_rd_q;
        mem_wr_d       = mem_wr_q;
        mem_addr_d     = mem_addr_q;
        mem_be_d       = mem_be_q;
        mem_wdata_d    = mem_wdata_q;
        wr_pend_d      = wr_pend_q;
        wr_pend_addr_d = wr_pend_addr_q;
        wr_pend_data_d = wr_pend_data_q;
        fill_kill_d    = fill_kill_q;
        w_addr         = ram_addr;
        w_data         = ram_di;
        upd_en         = 1'b0;
        upd_tag        = RAM_BASE + MEM_AW'(ram_addr[16:1]);
        rom_fill_en    = 1'b0;
        ram_fill_en    = 1'b0;
        cpu_stall      = 1'b0;

        unique case (state_q)
            IDLE: begin
                fill_kill_d = 1'b0;
                cpu_stall   = wr_edge || wr_pend_q || ram_miss || rom_miss;
                if (wr_pend_q || wr_edge) begin
                    // A latched write goes first; a fresh edge in the same
                    // cycle takes its place in the pending slot.
                    if (wr_pend_q) begin
                        w_addr    = wr_pend_addr_q;
                        w_data    = wr_pend_data_q;
                        wr_pend_d = wr_edge;
                        if (wr_edge) begin
                            wr_pend_addr_d = ram_addr;
                            wr_pend_data_d = ram_di;
                        end
                    end
                    upd_tag     = RAM_BASE + MEM_AW'(w_addr[16:1]);
                    upd_en      = 1'b1;
                    state_d     = WR_RAM;
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = upd_tag;
                    mem_be_d    = lane_be(w_addr[0]);
                    mem_wdata_d = {w_data, w_data};
                end else if (ram_miss) begin
                    state_d    = RD_RAM;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = ram_tag;
                    mem_be_d   = BE_WORD;
                end else if (rom_miss) begin
                    state_d    = RD_ROM;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = rom_tag;
                    mem_be_d   = BE_WORD;
                end
            end
            RD_ROM, RD_RAM, WR_RAM: begin
                cpu_stall = 1'b1;
                if (flush) fill_kill_d = 1'b1;
                if (wr_edge) begin
                    wr_pend_d      = 1'b1;
                    wr_pend_addr_d = ram_addr;
                    wr_pend_data_d = ram_di;
                end
                if (mem.mem_ack) begin
                    state_d     = IDLE;
                    mem_rd_d    = 1'b0;
                    mem_wr_d    = 1'b0;
                    fill_kill_d = 1'b0;
                    // A flush seen at any point of the fill discards its data.
                    rom_fill_en = (state_q == RD_ROM) && !fill_kill_q && !flush;
                    ram_fill_en = (state_q == RD_RAM) && !fill_kill_q && !flush;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cart_mem_bridge.sv
// Directed bench for cart_mem_bridge: reset values, ROM/RAM fills and hits,
// write-through, write during fill, flush during fill and mid-transaction reset.
module tb_cart_mem_bridge;

    logic        clk_sys;
    logic        reset;
    logic        flush;
    logic [22:0] rom_addr;
    logic        rom_rd;
    logic [7:0]  rom_data;
    logic [16:0] ram_addr;
    logic        ram_rd;
    logic        ram_wr;
    logic [7:0]  ram_di;
    logic [7:0]  ram_do;
    logic        cpu_stall;

    cart_mem_bridge_if #(.MEM_AW(22)) mif ();

    cart_mem_bridge #(
        .MEM_AW   (22),
        .ROM_BASE (22'h000000),
        .RAM_BASE (22'h200000)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .flush     (flush),
        .rom_addr  (rom_addr),
        .rom_rd    (rom_rd),
        .rom_data  (rom_data),
        .ram_addr  (ram_addr),
        .ram_rd    (ram_rd),
        .ram_wr    (ram_wr),
        .ram_di    (ram_di),
        .ram_do    (ram_do),
        .cpu_stall (cpu_stall),
        .mem       (mif)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: explicit words plus a default pattern {~a[7:0], a[7:0]}.
    logic [15:0] model [int];
    bit          resp_en;
    int          resp_lat;
    int          n_rd, n_wr;
    logic [21:0] last_rd_addr, last_wr_addr;
    logic [1:0]  last_be;
    logic [15:0] last_wdata;
    logic        last_kind;    // 0 = read, 1 = write

    function automatic logic [15:0] model_read(input int a);
        logic [7:0] lo;
        if (model.exists(a)) return model[a];
        lo = a[7:0];
        return {~lo, lo};
    endfunction

    // Responder: sees a request at a falling edge, acks resp_lat cycles later.
    initial begin : responder
        logic [15:0] w;
        forever begin
            @(negedge clk_sys);
            if (resp_en) mif.mem_ack = 1'b0;
            if (resp_en && (mif.mem_rd || mif.mem_wr)) begin
                if (mif.mem_rd) begin
                    n_rd++;
                    last_rd_addr = mif.mem_addr;
                    last_kind    = 1'b0;
                end else begin
                    n_wr++;
                    last_wr_addr = mif.mem_addr;
                    last_be      = mif.mem_be;
                    last_wdata   = mif.mem_wdata;
                    last_kind    = 1'b1;
                end
                repeat (resp_lat) @(negedge clk_sys);
                if (mif.mem_rd) begin
                    mif.mem_rdata = model_read(int'(mif.mem_addr));
                end else begin
                    w = model_read(int'(mif.mem_addr));
                    if (mif.mem_be[0]) w[7:0]  = mif.mem_wdata[7:0];
                    if (mif.mem_be[1]) w[15:8] = mif.mem_wdata[15:8];
                    model[int'(mif.mem_addr)] = w;
                end
                mif.mem_ack = 1'b1;
            end
        end
    end

    // Read and write requests must never be raised together.
    initial begin : excl_mon
        forever begin
            @(posedge clk_sys);
            #2;
            check("rd_wr_exclusive", {31'd0, mif.mem_rd & mif.mem_wr}, 32'd0);
        end
    end

    // Counts stalled cycles from the current one until stall drops (bounded).
    task automatic wait_idle(input string name, output int n);
        n = 0;
        while (cpu_stall && n < 60) begin
            n++;
            @(negedge clk_sys);
            #1;
        end
        if (cpu_stall) check({name, "_timeout"}, {31'd0, cpu_stall}, 32'd0);
    endtask

    task automatic wait_mem_rd(input string name);
        int n;
        n = 0;
        while (!mif.mem_rd && n < 20) begin
            n++;
            @(negedge clk_sys);
            #1;
        end
        if (!mif.mem_rd) check({name, "_timeout"}, {31'd0, mif.mem_rd}, 32'd1);
    endtask

    typedef struct {
        logic [22:0] rom_addr;
        logic [16:0] ram_addr;
        logic [7:0]  exp_rom;
        logic [7:0]  exp_ram;
    } vec_t;

    vec_t vecs [4];

    initial begin : main
        int n;
        int rd0, wr0;

        // Hit table, valid once ROM word 0xA8 = 16'h57A8 and RAM word
        // 0x200001 = 16'hA577 are cached.
        vecs[0] = '{rom_addr: 23'h000150, ram_addr: 17'h00002, exp_rom: 8'hA8, exp_ram: 8'h77};
        vecs[1] = '{rom_addr: 23'h000151, ram_addr: 17'h00003, exp_rom: 8'h57, exp_ram: 8'hA5};
        vecs[2] = '{rom_addr: 23'h000150, ram_addr: 17'h00003, exp_rom: 8'hA8, exp_ram: 8'hA5};
        vecs[3] = '{rom_addr: 23'h000151, ram_addr: 17'h00002, exp_rom: 8'h57, exp_ram: 8'h77};

        model[32'h200001] = 16'h1234;
        resp_en  = 1'b1;
        resp_lat = 3;
        n_rd = 0;
        n_wr = 0;
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = 16'h0000;
        reset    = 1'b1;
        flush    = 1'b0;
        rom_addr = 23'h0;
        rom_rd   = 1'b0;
        ram_addr = 17'h0;
        ram_rd   = 1'b0;
        ram_wr   = 1'b0;
        ram_di   = 8'h00;

        // Reset values.
        repeat (3) @(negedge clk_sys);
        #1;
        check("rst_mem_rd",    {31'd0, mif.mem_rd}, 32'd0);
        check("rst_mem_wr",    {31'd0, mif.mem_wr}, 32'd0);
        check("rst_mem_addr",  {10'd0, mif.mem_addr}, 32'd0);
        check("rst_mem_be",    {30'd0, mif.mem_be}, 32'd0);
        check("rst_mem_wdata", {16'd0, mif.mem_wdata}, 32'd0);
        check("rst_stall",     {31'd0, cpu_stall}, 32'd0);
        check("rst_rom_data",  {24'd0, rom_data}, 32'h0FF);
        check("rst_ram_do",    {24'd0, ram_do}, 32'h0FF);
        @(negedge clk_sys);
        reset = 1'b0;

        // ROM miss at 0x0150, ack three cycles after mem_rd rises.
        @(negedge clk_sys);
        rom_addr = 23'h000150;
        rom_rd   = 1'b1;
        #1;
        check("rom_miss_stall_n",  {31'd0, cpu_stall}, 32'd1);
        check("rom_miss_rd_n",     {31'd0, mif.mem_rd}, 32'd0);
        @(negedge clk_sys);
        #1;
        check("rom_miss_rd_n1",    {31'd0, mif.mem_rd}, 32'd1);
        check("rom_miss_addr",     {10'd0, mif.mem_addr}, 32'h0000A8);
        wait_idle("rom_miss", n);
        check("rom_miss_stall_cycles", n + 1, 32'd5);
        check("rom_fill_lo",       {24'd0, rom_data}, 32'h0A8);
        check("rom_fill_nrd",      n_rd, 32'd1);
        check("rom_fill_rd_addr",  {10'd0, last_rd_addr}, 32'h0000A8);
        @(negedge clk_sys);
        rom_addr = 23'h000151;
        #1;
        check("rom_hit_hi",        {24'd0, rom_data}, 32'h057);
        check("rom_hit_stall",     {31'd0, cpu_stall}, 32'd0);
        repeat (4) @(negedge clk_sys);
        check("rom_hit_no_traffic", n_rd, 32'd1);
        rom_rd = 1'b0;

        // RAM fill of 0x00002, then write-through of 0x77 to the same byte.
        @(negedge clk_sys);
        ram_addr = 17'h00002;
        ram_rd   = 1'b1;
        #1;
        wait_idle("ram_fill", n);
        check("ram_fill_data",  {24'd0, ram_do}, 32'h034);
        check("ram_fill_nrd",   n_rd, 32'd2);
        check("ram_fill_addr",  {10'd0, last_rd_addr}, 32'h200001);
        @(negedge clk_sys);
        ram_rd = 1'b0;
        ram_wr = 1'b1;
        ram_di = 8'h77;
        #1;
        check("wr77_stall",     {31'd0, cpu_stall}, 32'd1);
        wait_idle("wr77", n);
        check("wr77_nwr",       n_wr, 32'd1);
        check("wr77_be",        {30'd0, last_be}, 32'h1);
        check("wr77_wdata",     {16'd0, last_wdata}, 32'h7777);
        check("wr77_addr",      {10'd0, last_wr_addr}, 32'h200001);
        @(negedge clk_sys);
        ram_wr = 1'b0;
        ram_rd = 1'b1;
        #1;
        check("wr77_rd_lo",     {24'd0, ram_do}, 32'h077);
        check("wr77_rd_stall",  {31'd0, cpu_stall}, 32'd0);
        @(negedge clk_sys);
        ram_addr = 17'h00003;
        #1;
        check("wr77_rd_hi",     {24'd0, ram_do}, 32'h012);
        repeat (3) @(negedge clk_sys);
        check("wr77_no_fill",   n_rd, 32'd2);
        ram_rd = 1'b0;

        // Write 0xA5 to 0x00003 with ram_wr held for ten cycles.
        @(negedge clk_sys);
        ram_addr = 17'h00003;
        ram_di   = 8'hA5;
        ram_wr   = 1'b1;
        #1;
        check("wrA5_stall",     {31'd0, cpu_stall}, 32'd1);
        repeat (10) @(negedge clk_sys);
        #1;
        ram_wr = 1'b0;
        check("wrA5_nwr",       n_wr, 32'd2);
        check("wrA5_be",        {30'd0, last_be}, 32'h2);
        check("wrA5_wdata",     {16'd0, last_wdata}, 32'hA5A5);
        check("wrA5_addr",      {10'd0, last_wr_addr}, 32'h200001);
        check("wrA5_stall_end", {31'd0, cpu_stall}, 32'd0);

        // Combinational hit table over both caches.
        rd0 = n_rd;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_sys);
            rom_rd   = 1'b1;
            ram_rd   = 1'b1;
            rom_addr = vecs[i].rom_addr;
            ram_addr = vecs[i].ram_addr;
            #1;
            check($sformatf("vec%0d_rom", i), {24'd0, rom_data}, {24'd0, vecs[i].exp_rom});
            check($sformatf("vec%0d_ram", i), {24'd0, ram_do}, {24'd0, vecs[i].exp_ram});
            check($sformatf("vec%0d_stall", i), {31'd0, cpu_stall}, 32'd0);
        end
        repeat (3) @(negedge clk_sys);
        check("vec_no_traffic", n_rd, rd0);
        ram_rd = 1'b0;

        // Write edge while a ROM fill of 0x0300 is outstanding.
        resp_lat = 4;
        rd0 = n_rd;
        wr0 = n_wr;
        @(negedge clk_sys);
        rom_addr = 23'h000300;
        #1;
        wait_mem_rd("wdf_rd");
        ram_addr = 17'h00010;
        ram_di   = 8'h3C;
        ram_wr   = 1'b1;
        #1;
        wait_idle("wdf", n);
        ram_wr = 1'b0;
        check("wdf_nrd",      n_rd - rd0, 32'd1);
        check("wdf_rd_addr",  {10'd0, last_rd_addr}, 32'h000180);
        check("wdf_nwr",      n_wr - wr0, 32'd1);
        check("wdf_wr_last",  {31'd0, last_kind}, 32'd1);
        check("wdf_wr_addr",  {10'd0, last_wr_addr}, 32'h200008);
        check("wdf_wr_be",    {30'd0, last_be}, 32'h1);
        check("wdf_wr_wdata", {16'd0, last_wdata}, 32'h3C3C);
        check("wdf_rom_data", {24'd0, rom_data}, 32'h080);

        // Flush during a ROM fill of 0x0400: the fill is dropped and redone.
        rd0 = n_rd;
        @(negedge clk_sys);
        rom_addr = 23'h000400;
        #1;
        wait_mem_rd("fl_rd");
        @(negedge clk_sys);
        flush = 1'b1;
        @(negedge clk_sys);
        flush = 1'b0;
        #1;
        wait_idle("fl", n);
        check("fl_refill_nrd",  n_rd - rd0, 32'd2);
        check("fl_refill_addr", {10'd0, last_rd_addr}, 32'h000200);
        check("fl_rom_data",    {24'd0, rom_data}, 32'h000);
        @(negedge clk_sys);
        rom_rd   = 1'b0;
        ram_addr = 17'h00002;
        ram_rd   = 1'b1;
        #1;
        check("fl_ram_miss",    {31'd0, cpu_stall}, 32'd1);
        wait_idle("fl_ram", n);
        check("fl_ram_nrd",     n_rd - rd0, 32'd3);
        check("fl_ram_data",    {24'd0, ram_do}, 32'h077);
        ram_rd = 1'b0;

        // Reset while mem_rd is high; a late ack afterwards must be ignored.
        repeat (2) @(negedge clk_sys);
        resp_en = 1'b0;
        @(negedge clk_sys);
        rom_addr = 23'h000500;
        rom_rd   = 1'b1;
        #1;
        wait_mem_rd("rst_rd");
        @(negedge clk_sys);
        reset  = 1'b1;
        rom_rd = 1'b0;
        @(negedge clk_sys);
        #1;
        check("mid_rst_mem_rd",   {31'd0, mif.mem_rd}, 32'd0);
        check("mid_rst_mem_wr",   {31'd0, mif.mem_wr}, 32'd0);
        check("mid_rst_addr",     {10'd0, mif.mem_addr}, 32'd0);
        check("mid_rst_be",       {30'd0, mif.mem_be}, 32'd0);
        check("mid_rst_wdata",    {16'd0, mif.mem_wdata}, 32'd0);
        check("mid_rst_stall",    {31'd0, cpu_stall}, 32'd0);
        check("mid_rst_ram_do",   {24'd0, ram_do}, 32'h0FF);
        reset = 1'b0;
        @(negedge clk_sys);
        mif.mem_rdata = 16'hDEAD;
        mif.mem_ack   = 1'b1;
        @(negedge clk_sys);
        mif.mem_ack = 1'b0;
        #1;
        check("late_ack_mem_rd",  {31'd0, mif.mem_rd}, 32'd0);
        @(negedge clk_sys);
        rom_rd = 1'b1;
        #1;
        check("late_ack_rom_ff",  {24'd0, rom_data}, 32'h0FF);
        check("late_ack_miss",    {31'd0, cpu_stall}, 32'd1);
        resp_en = 1'b1;
        wait_idle("post_rst", n);
        check("post_rst_rom",     {24'd0, rom_data}, 32'h080);
        rom_rd = 1'b0;
        repeat (3) @(negedge clk_sys);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
